// File: rtl/systolic_pkg.sv
// Shared tile geometry and loader state encoding for the systolic array front end.
package systolic_pkg;

  localparam int unsigned DIM  = 8;
  localparam int unsigned BITS = 8;

  typedef enum logic [1:0] {
    StLoad  = 2'd0,
    StFull  = 2'd1,
    StDrain = 2'd2
  } loader_state_e;

endpackage

// File: rtl/fifo_loader_if.sv
// Row-load handshake, drain request and delay-fifo drive bundle for fifo_loader.
interface fifo_loader_if #(
  parameter int unsigned DIM  = systolic_pkg::DIM,
  parameter int unsigned BITS = systolic_pkg::BITS
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic [DIM*BITS-1:0]     in_data;
  logic                    start;
  logic [DIM*BITS-1:0]     fifo_d;
  logic [DIM-1:0]          fifo_en;
  logic [$clog2(DIM):0]    row_count;
  logic                    busy;
  logic                    drain_done;

  modport master (
    output in_valid, in_data, start,
    input  in_ready, fifo_d, fifo_en, row_count, busy, drain_done
  );

  modport slave (
    input  in_valid, in_data, start,
    output in_ready, fifo_d, fifo_en, row_count, busy, drain_done
  );

endinterface

// File: rtl/skew_gen.sv
// Per-lane drain window: lane k shifts while k <= c <= k+DIM-1.
module skew_gen #(
  parameter int unsigned DIM = systolic_pkg::DIM,
  parameter int unsigned CW  = $clog2(2 * DIM)
) (
  input  logic [CW-1:0]  c_i,
  input  logic           active_i,
  output logic [DIM-1:0] en_o
);

  for (genvar k = 0; k < DIM; k++) begin : g_lane
    localparam logic [CW-1:0] Lo = CW'(k);
    localparam logic [CW-1:0] Hi = CW'(k + DIM - 1);
    assign en_o[k] = active_i && (c_i >= Lo) && (c_i <= Hi);
  end

endmodule

// File: rtl/fifo_loader.sv
// Loads DIM rows into the delay fifos, then drains them with a per-lane skew of one cycle.
module fifo_loader
  import systolic_pkg::*;
#(
  parameter int unsigned DIM  = systolic_pkg::DIM,
  parameter int unsigned BITS = systolic_pkg::BITS
) (
  input  logic           clk,
  input  logic           rst,
  fifo_loader_if.slave   bus
);

  localparam int unsigned CW = $clog2(2 * DIM);
  localparam int unsigned RW = $clog2(DIM) + 1;
  localparam logic [CW-1:0] CLast = CW'(2 * DIM - 2);
  localparam logic [RW-1:0] RLast = RW'(DIM - 1);

  loader_state_e         state_q;
  logic [RW-1:0]         row_count_q;
  logic [CW-1:0]         c_q;
  logic [DIM-1:0]        fifo_en_q;
  logic [DIM*BITS-1:0]   fifo_d_q;
  logic                  drain_done_q;

  // Window is evaluated for the drain count of the next cycle so fifo_en lines up with c.
  logic [CW-1:0]  skew_c;
  logic           skew_active;
  logic [DIM-1:0] skew_en;

  assign skew_c      = (state_q == StDrain) ? c_q + CW'(1) : '0;
  assign skew_active = ((state_q == StFull) && bus.start) ||
                       ((state_q == StDrain) && (c_q != CLast));

  skew_gen #(
    .DIM (DIM),
    .CW  (CW)
  ) u_skew_gen (
    .c_i      (skew_c),
    .active_i (skew_active),
    .en_o     (skew_en)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StLoad;
      row_count_q  <= '0;
      c_q          <= '0;
      fifo_en_q    <= '0;
      fifo_d_q     <= '0;
      drain_done_q <= 1'b0;
    end else begin
      fifo_en_q    <= skew_en;
      fifo_d_q     <= '0;
      drain_done_q <= 1'b0;
      unique case (state_q)
        StLoad: begin
          if (bus.in_valid) begin
            fifo_en_q   <= '1;
            fifo_d_q    <= bus.in_data;
            row_count_q <= row_count_q + RW'(1);
            if (row_count_q == RLast) begin
              state_q <= StFull;
            end
          end
        end
        StFull: begin
          if (bus.start) begin
            state_q <= StDrain;
            c_q     <= '0;
          end
        end
        StDrain: begin
          if (c_q == CLast) begin
            state_q      <= StLoad;
            row_count_q  <= '0;
            c_q          <= '0;
            drain_done_q <= 1'b1;
          end else begin
            c_q <= c_q + CW'(1);
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  assign bus.in_ready   = (state_q == StLoad);
  assign bus.busy       = (state_q != StLoad);
  assign bus.fifo_en    = fifo_en_q;
  assign bus.fifo_d     = fifo_d_q;
  assign bus.row_count  = row_count_q;
  assign bus.drain_done = drain_done_q;

endmodule

// File: tb/tb_fifo_loader.sv
// Directed and randomized checks of fifo_loader against a tile-level reference model.
module tb_fifo_loader;
  import systolic_pkg::*;

  localparam int DW = DIM * BITS;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  fifo_loader_if #(.DIM(DIM), .BITS(BITS)) bus ();

  fifo_loader #(
    .DIM  (DIM),
    .BITS (BITS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 = loading, 1 = tile full, 2 = draining.
  int             m_phase;
  int             m_rows;
  int             m_c;
  logic [DIM-1:0] m_en;
  logic [DW-1:0]  m_d;
  logic           m_done;

  function automatic logic [DIM-1:0] window(input int c);
    logic [DIM-1:0] w;
    for (int k = 0; k < DIM; k++) w[k] = (c >= k) && (c <= k + DIM - 1);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_phase = 0; m_rows = 0; m_c = 0; m_en = '0; m_d = '0; m_done = 1'b0;
    end else begin
      m_en = '0; m_d = '0; m_done = 1'b0;
      if (m_phase == 0) begin
        if (bus.in_valid) begin
          m_en = '1; m_d = bus.in_data; m_rows++;
          if (m_rows == DIM) m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (bus.start) begin
          m_phase = 2; m_c = 0; m_en = window(0);
        end
      end else begin
        if (m_c == 2 * DIM - 2) begin
          m_phase = 0; m_rows = 0; m_c = 0; m_done = 1'b1;
        end else begin
          m_c++; m_en = window(m_c);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("fifo_en", DW'(bus.fifo_en), DW'(m_en));
    chk("fifo_d", bus.fifo_d, m_d);
    chk("row_count", DW'(bus.row_count), DW'(m_rows));
    chk("in_ready", DW'(bus.in_ready), DW'(m_phase == 0));
    chk("busy", DW'(bus.busy), DW'(m_phase != 0));
    chk("drain_done", DW'(bus.drain_done), DW'(m_done));
  endtask

  function automatic logic [DIM-1:0] drain_seq(input int i);
    logic [DIM-1:0] ones;
    ones = '1;
    if (i < DIM) return ones >> (DIM - 1 - i);
    return ones << (i - DIM + 1);
  endfunction

  initial begin
    logic [DW-1:0] base;
    int pulses;
    int accepts;
    base = 64'h0807060504030201;
    rst = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0; bus.start = 1'b0;
    m_phase = 0; m_rows = 0; m_c = 0; m_en = '0; m_d = '0; m_done = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Eight back-to-back rows fill the tile.
    for (int r = 0; r < DIM; r++) begin
      bus.in_valid = 1'b1; bus.in_data = base + DW'(r);
      step();
      chk("load_en_ff", DW'(bus.fifo_en), DW'({DIM{1'b1}}));
      chk("load_rowcnt", DW'(bus.row_count), DW'(r + 1));
    end
    chk("full_ready_low", DW'(bus.in_ready), '0);

    // in_valid stays high through FULL and DRAIN and must be ignored.
    for (int i = 0; i < 3; i++) begin
      bus.in_data = DW'({$urandom, $urandom});
      step();
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 2 * DIM - 1; i++) begin
      if (i > 0) step();
      chk("drain_seq", DW'(bus.fifo_en), DW'(drain_seq(i)));
      chk("drain_rowcnt", DW'(bus.row_count), DW'(DIM));
    end
    bus.in_valid = 1'b0;
    step();
    chk("drain_done_pulse", DW'(bus.drain_done), DW'(1));
    chk("drain_clear_rows", DW'(bus.row_count), '0);
    step();
    chk("drain_done_once", DW'(bus.drain_done), '0);

    // start during LOAD with three rows is ignored.
    for (int r = 0; r < 3; r++) begin
      bus.in_valid = 1'b1; bus.in_data = DW'({$urandom, $urandom});
      step();
    end
    bus.in_valid = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("load_start_rows", DW'(bus.row_count), DW'(3));
    chk("load_start_en", DW'(bus.fifo_en), '0);
    step();
    chk("load_start_ready", DW'(bus.in_ready), DW'(1));

    // Sparse valid: one accept every third cycle.
    pulses = 0; accepts = 0;
    for (int i = 0; i < 3 * (DIM - 3); i++) begin
      bus.in_valid = (i % 3 == 0); bus.in_data = DW'({$urandom, $urandom});
      if (bus.in_valid && bus.in_ready) accepts++;
      step();
      if (bus.fifo_en == '1) pulses++;
    end
    bus.in_valid = 1'b0;
    step();
    chk("gap_pulses", DW'(pulses), DW'(accepts));
    chk("gap_full", DW'(bus.busy && !bus.in_ready), DW'(1));
    chk("gap_rows", DW'(bus.row_count), DW'(DIM));

    // Reset in the middle of a drain at c = 5.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_en", DW'(bus.fifo_en), '0);
    chk("rst_ready", DW'(bus.in_ready), DW'(1));
    chk("rst_rows", DW'(bus.row_count), '0);
    for (int i = 0; i < 2 * DIM; i++) begin
      step();
      chk("rst_no_done", DW'(bus.drain_done), '0);
    end

    // Random traffic with occasional reset.
    for (int i = 0; i < 600; i++) begin
      rst          = ($urandom_range(0, 79) == 0);
      bus.in_valid = ($urandom_range(0, 2) != 0);
      bus.start    = ($urandom_range(0, 3) == 0);
      bus.in_data  = DW'({$urandom, $urandom});
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
